// File: rtl/sync_edge_pkg.sv
// Shared definitions for the multi-channel edge capture block.
//   edge_mode_e    : which level transition of a channel produces a pulse
//   ev_state_e     : event word handshake state
//   filt_cnt_width : width of the per-channel glitch filter counter
package sync_edge_pkg;

    typedef enum logic [1:0] {
        EdgeRising  = 2'd0,
        EdgeFalling = 2'd1,
        EdgeBoth    = 2'd2
    } edge_mode_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StValid = 1'b1
    } ev_state_e;

    // A bypassed filter (0) still gets a 1-bit counter so the declaration stays legal.
    function automatic int unsigned filt_cnt_width(input int unsigned filter);
        return (filter == 0) ? 1 : $clog2(filter + 1);
    endfunction

endpackage

// File: rtl/sync_filter.sv
// One input channel: SYNC-flop synchroniser, glitch filter and edge pulse generator.
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   in_async   in   asynchronous level input
//   out_level  out  filtered, synchronised level (registered)
//   out_pulse  out  one-cycle pulse on the selected edge of out_level (registered)
module sync_filter
    import sync_edge_pkg::*;
#(
    parameter int unsigned SYNC      = 2,
    parameter int unsigned FILTER    = 4,
    parameter edge_mode_e  EDGE_MODE = EdgeBoth
) (
    input  logic clock,
    input  logic reset,
    input  logic in_async,
    output logic out_level,
    output logic out_pulse
);

    localparam int unsigned     CntW    = filt_cnt_width(FILTER);
    localparam logic [CntW-1:0] CntLast = (FILTER == 0) ? '0 : CntW'(FILTER - 1);

    // Pure flop chain, nothing between stages.
    (* ASYNC_REG = "TRUE" *) logic [SYNC-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], in_async};
        end
    end

    logic            s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic            rise, fall;

    assign s = sync_q[SYNC-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (FILTER == 0) begin
            level_d = s;
        end else if (s != level_q) begin
            // Level only follows s after FILTER consecutive mismatching cycles.
            if (cnt_q == CntLast) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        rise = level_d & ~level_q;
        fall = ~level_d & level_q;
        case (EDGE_MODE)
            EdgeRising:  pulse_d = rise;
            EdgeFalling: pulse_d = fall;
            default:     pulse_d = rise | fall;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign out_level = level_q;
    assign out_pulse = pulse_q;

endmodule

// File: rtl/sync_edge_capture.sv
// Multi-channel synchroniser / debouncer / edge detector that merges detected edges into an
// event word delivered over a valid/ready handshake. Edges arriving while a word is presented
// accumulate in a pending word, so none are dropped; repeat edges on a bit are flagged as overflow.
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   in_async     in   [CHANNELS] asynchronous level inputs
//   out_level    out  [CHANNELS] filtered, synchronised levels
//   out_pulse    out  [CHANNELS] one-cycle pulse per selected edge
//   ev_data      out  [CHANNELS] channels with an event since the last transfer
//   ev_overflow  out  an event was merged into an already-set bit
//   ev_valid     out  ev_data / ev_overflow are valid
//   ev_time      out  [TIME_BITS] timestamp of first pulse in word (SYNC_EDGE_TIMESTAMP_EN only)
//   ev_ready     in   consumer accepts the event word
// Build option: define SYNC_EDGE_TIMESTAMP_EN to add the free-running timestamp and ev_time.
module sync_edge_capture
    import sync_edge_pkg::*;
#(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned SYNC      = 2,
    parameter int unsigned FILTER    = 4,
    parameter string       EDGE      = "BOTH",
    parameter int unsigned TIME_BITS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_async,
    output logic [CHANNELS-1:0] out_level,
    output logic [CHANNELS-1:0] out_pulse,
    output logic [CHANNELS-1:0] ev_data,
    output logic                ev_overflow,
    output logic                ev_valid,
`ifdef SYNC_EDGE_TIMESTAMP_EN
    output logic [TIME_BITS-1:0] ev_time,
`endif
    input  logic                ev_ready
);

    localparam edge_mode_e EdgeMode = (EDGE == "RISING")  ? EdgeRising  :
                                      (EDGE == "FALLING") ? EdgeFalling : EdgeBoth;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sync_filter #(
            .SYNC      (SYNC),
            .FILTER    (FILTER),
            .EDGE_MODE (EdgeMode)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .in_async  (in_async[i]),
            .out_level (out_level[i]),
            .out_pulse (out_pulse[i])
        );
    end

    ev_state_e           state_q;
    logic [CHANNELS-1:0] pending_q;
    logic                pend_ov_q;
    logic [CHANNELS-1:0] ev_data_q;
    logic                ev_overflow_q;
    logic                ev_valid_q;

    logic [CHANNELS-1:0] merged;
    logic                merge_ov;
    logic                data_ov;
    logic                handshake;
    logic                load;

    assign merged    = pending_q | out_pulse;
    assign merge_ov  = |(out_pulse & pending_q);
    assign data_ov   = |(out_pulse & ev_data_q);
    assign handshake = ev_valid_q & ev_ready;
    // New word is taken either from idle or in the accepting cycle (back-to-back, no bubble).
    assign load      = ((state_q == StIdle) || handshake) && (|merged);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            pend_ov_q     <= 1'b0;
            ev_data_q     <= '0;
            ev_overflow_q <= 1'b0;
            ev_valid_q    <= 1'b0;
        end else if (load) begin
            ev_data_q     <= merged;
            ev_overflow_q <= pend_ov_q | merge_ov;
            pending_q     <= '0;
            pend_ov_q     <= 1'b0;
            ev_valid_q    <= 1'b1;
            state_q       <= StValid;
        end else if (handshake) begin
            ev_valid_q <= 1'b0;
            state_q    <= StIdle;
        end else if (state_q == StValid) begin
            // Presented word stays frozen; new edges collect in pending.
            pending_q <= merged;
            pend_ov_q <= pend_ov_q | merge_ov | data_ov;
        end
    end

    assign ev_data     = ev_data_q;
    assign ev_overflow = ev_overflow_q;
    assign ev_valid    = ev_valid_q;

`ifdef SYNC_EDGE_TIMESTAMP_EN
    logic [TIME_BITS-1:0] time_q;
    logic [TIME_BITS-1:0] pend_time_q;
    logic [TIME_BITS-1:0] ev_time_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            time_q      <= '0;
            pend_time_q <= '0;
            ev_time_q   <= '0;
        end else begin
            time_q <= time_q + 1'b1;
            if (load) begin
                // A non-empty pending word already recorded when its first pulse arrived.
                ev_time_q <= (|pending_q) ? pend_time_q : time_q;
            end else if ((state_q == StValid) && !handshake && (pending_q == '0) &&
                         (|out_pulse)) begin
                pend_time_q <= time_q;
            end
        end
    end

    assign ev_time = ev_time_q;
`endif

endmodule
